// File: rtl/td4_core_param.sv
// TD4-style 4-bit-family CPU core with width parameter W: A/B registers, carry flag,
// registered output port and a RUN/HALT controller. One instruction per enabled clock edge.
module td4_core_param #(
    parameter int W       = 4,
    parameter int INSTR_W = 4 + W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    output logic [W-1:0]       addres,
    input  logic [INSTR_W-1:0] data,
    input  logic [W-1:0]       port_i,
    output logic [W-1:0]       port_o,
    output logic               port_o_stb,
    output logic               cf,
    output logic               halted
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_t         state, state_nxt;
    logic [W-1:0]   pc, a, b;
    logic [W-1:0]   pc_nxt, a_nxt, b_nxt, port_nxt;
    logic           cf_nxt, stb_nxt, exec;
    logic [3:0]     op;
    logic [W-1:0]   imm, src, addend;
    logic [W:0]     sum;

    assign op     = data[INSTR_W-1 -: 4];
    assign imm    = data[W-1:0];
    assign exec   = (state == RUN) && ena;
    assign addres = pc;
    assign halted = (state == HALT);

    // Single adder: every opcode is src + addend; ADD A,B is the only one not adding imm.
    always_comb begin
        addend = imm;
        src    = '0;
        case (op)
            4'h0, 4'h4: src = a;
            4'h1, 4'h5, 4'h9: src = b;
            4'h2, 4'h6: src = port_i;
            4'h8: begin
                src    = a;
                addend = b;
            end
            default: src = '0;
        endcase
        sum = {1'b0, src} + {1'b0, addend};
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        a_nxt     = a;
        b_nxt     = b;
        port_nxt  = port_o;
        cf_nxt    = cf;
        stb_nxt   = 1'b0;
        if (exec) begin
            pc_nxt = pc + ONE;
            cf_nxt = sum[W];
            case (op)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h8: a_nxt = sum[W-1:0];
                4'h4, 4'h5, 4'h6, 4'h7:       b_nxt = sum[W-1:0];
                4'h9, 4'hB: begin
                    port_nxt = sum[W-1:0];
                    stb_nxt  = 1'b1;
                end
                4'hA: begin
                    state_nxt = HALT;
                    pc_nxt    = pc;
                    cf_nxt    = cf;
                end
                // Jump condition looks at cf before this instruction rewrites it.
                4'hC: if (cf)  pc_nxt = sum[W-1:0];
                4'hD: cf_nxt = cf;
                4'hE: if (!cf) pc_nxt = sum[W-1:0];
                4'hF: pc_nxt = sum[W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= '0;
            a          <= '0;
            b          <= '0;
            port_o     <= '0;
            cf         <= 1'b0;
            port_o_stb <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            a          <= a_nxt;
            b          <= b_nxt;
            port_o     <= port_nxt;
            cf         <= cf_nxt;
            port_o_stb <= stb_nxt;
        end
    end

endmodule

// File: tb/tb_td4_core_param.sv
// Bench for td4_core_param: directed scenarios on W=4 and W=8 instances plus a
// randomized W=4 run compared against an integer-arithmetic instruction-level model.
module tb_td4_core_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4 = 1'b1, ena4 = 1'b0, stb4, cf4, halt4;
    logic [3:0]  addr4, pi4 = '0, po4;
    logic [7:0]  data4;
    logic [7:0]  mem4 [16];

    logic        rst8 = 1'b1, ena8 = 1'b0, stb8, cf8, halt8;
    logic [7:0]  addr8, pi8 = '0, po8;
    logic [11:0] data8;
    logic [11:0] mem8 [256];

    int n_chk  = 0;
    int n_fail = 0;

    assign data4 = mem4[addr4];
    assign data8 = mem8[addr8];

    td4_core_param #(.W(4)) d4 (
        .clk(clk), .rst(rst4), .ena(ena4), .addres(addr4), .data(data4),
        .port_i(pi4), .port_o(po4), .port_o_stb(stb4), .cf(cf4), .halted(halt4)
    );

    td4_core_param #(.W(8)) d8 (
        .clk(clk), .rst(rst8), .ena(ena8), .addres(addr8), .data(data8),
        .port_i(pi8), .port_o(po8), .port_o_stb(stb8), .cf(cf8), .halted(halt8)
    );

    // Observation vectors: {pc, port_o, stb, cf, halted}
    function automatic logic [10:0] obs4();
        return {addr4, po4, stb4, cf4, halt4};
    endfunction

    function automatic logic [18:0] obs8();
        return {addr8, po8, stb8, cf8, halt8};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear4();
        for (int i = 0; i < 16; i++) mem4[i] = 8'hD0;
    endtask

    task automatic reset4();
        rst4 = 1'b1;
        ena4 = 1'b1;
        tick();
        rst4 = 1'b0;
    endtask

    task automatic reset8();
        rst8 = 1'b1;
        ena8 = 1'b1;
        tick();
        rst8 = 1'b0;
    endtask

    // Reference model: architectural state as plain integers.
    int m_pc, m_a, m_b, m_po;
    bit m_cf, m_stb, m_halt;

    task automatic model_step(input bit r, input bit en, input logic [7:0] ins, input int pin);
        int op, imm, s, res, npc;
        m_stb = 0;
        if (r) begin
            m_pc = 0; m_a = 0; m_b = 0; m_po = 0; m_cf = 0; m_halt = 0;
        end else if (en && !m_halt) begin
            op  = int'(ins[7:4]);
            imm = int'(ins[3:0]);
            case (op)
                0, 4:    s = m_a + imm;
                1, 5, 9: s = m_b + imm;
                2, 6:    s = pin + imm;
                8:       s = m_a + m_b;
                default: s = imm;
            endcase
            res = s % 16;
            npc = (m_pc + 1) % 16;
            case (op)
                0, 1, 2, 3, 8: m_a = res;
                4, 5, 6, 7:    m_b = res;
                9, 11: begin m_po = res; m_stb = 1; end
                10: begin m_halt = 1; npc = m_pc; end
                12: if (m_cf)  npc = res;
                14: if (!m_cf) npc = res;
                15: npc = res;
                default: ;
            endcase
            m_pc = npc;
            if (op != 10 && op != 13) m_cf = (s >= 16);
        end
    endtask

    task automatic test_reset();
        logic [10:0] exp [3];
        exp = '{ {4'h0, 4'h0, 1'b0, 1'b0, 1'b0},
                 {4'h3, 4'h7, 1'b1, 1'b0, 1'b0},
                 {4'h0, 4'h0, 1'b0, 1'b0, 1'b0} };
        for (int i = 0; i < 16; i++) mem4[i] = 8'hB7;
        reset4();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin tick(); tick(); tick(); end
            if (i == 2) begin rst4 = 1'b1; ena4 = 1'b1; tick(); rst4 = 1'b0; end
            n_chk++;
            if (obs4() !== exp[i]) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", i, obs4(), exp[i]);
            end
        end
    endtask

    task automatic test_carry();
        logic [10:0] exp [4];
        clear4();
        mem4[0] = 8'h3F; mem4[1] = 8'h01; mem4[2] = 8'h43; mem4[3] = 8'h90;
        exp = '{ {4'h1, 4'h0, 1'b0, 1'b0, 1'b0},
                 {4'h2, 4'h0, 1'b0, 1'b1, 1'b0},
                 {4'h3, 4'h0, 1'b0, 1'b0, 1'b0},
                 {4'h4, 4'h3, 1'b1, 1'b0, 1'b0} };
        reset4();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (obs4() !== exp[i]) begin
                n_fail++;
                $display("FAIL carry[%0d]: got %h expected %h", i, obs4(), exp[i]);
            end
        end
    endtask

    task automatic test_jumps();
        logic [10:0] exp [8];
        clear4();
        mem4[0] = 8'h3F; mem4[1] = 8'h01; mem4[2] = 8'hE9; mem4[3] = 8'hC9;
        mem4[4] = 8'h0F; mem4[5] = 8'h01; mem4[6] = 8'hC9; mem4[9] = 8'hEC;
        exp = '{ {4'h1, 4'h0, 1'b0, 1'b0, 1'b0},
                 {4'h2, 4'h0, 1'b0, 1'b1, 1'b0},
                 {4'h3, 4'h0, 1'b0, 1'b0, 1'b0},
                 {4'h4, 4'h0, 1'b0, 1'b0, 1'b0},
                 {4'h5, 4'h0, 1'b0, 1'b0, 1'b0},
                 {4'h6, 4'h0, 1'b0, 1'b1, 1'b0},
                 {4'h9, 4'h0, 1'b0, 1'b0, 1'b0},
                 {4'hC, 4'h0, 1'b0, 1'b0, 1'b0} };
        reset4();
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (obs4() !== exp[i]) begin
                n_fail++;
                $display("FAIL jumps[%0d]: got %h expected %h", i, obs4(), exp[i]);
            end
        end
    endtask

    task automatic test_out();
        logic [10:0] exp [5];
        clear4();
        mem4[0] = 8'h75; mem4[1] = 8'h90; mem4[3] = 8'hB5;
        exp = '{ {4'h1, 4'h0, 1'b0, 1'b0, 1'b0},
                 {4'h2, 4'h5, 1'b1, 1'b0, 1'b0},
                 {4'h3, 4'h5, 1'b0, 1'b0, 1'b0},
                 {4'h4, 4'h5, 1'b1, 1'b0, 1'b0},
                 {4'h5, 4'h5, 1'b0, 1'b0, 1'b0} };
        reset4();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (obs4() !== exp[i]) begin
                n_fail++;
                $display("FAIL out[%0d]: got %h expected %h", i, obs4(), exp[i]);
            end
        end
    endtask

    task automatic test_halt();
        logic [10:0] exp;
        clear4();
        mem4[0] = 8'h3F; mem4[1] = 8'h01; mem4[3] = 8'hA0;
        reset4();
        for (int i = 0; i < 16; i++) begin
            if (i >= 4) begin ena4 = 1'($urandom); pi4 = 4'($urandom); end
            if (i == 14) begin rst4 = 1'b1; ena4 = 1'b0; end
            if (i == 15) begin rst4 = 1'b0; ena4 = 1'b1; end
            tick();
            case (i)
                0, 1:    exp = {4'(i + 1), 4'h0, 1'b0, i == 1, 1'b0};
                2:       exp = {4'h3, 4'h0, 1'b0, 1'b1, 1'b0};
                14:      exp = {4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
                15:      exp = {4'h1, 4'h0, 1'b0, 1'b0, 1'b0};
                default: exp = {4'h3, 4'h0, 1'b0, 1'b1, 1'b1};
            endcase
            n_chk++;
            if (obs4() !== exp) begin
                n_fail++;
                $display("FAIL halt[%0d]: got %h expected %h", i, obs4(), exp);
            end
        end
    endtask

    task automatic test_enable();
        logic [10:0] exp;
        clear4();
        mem4[0] = 8'hB3; mem4[1] = 8'hFA;
        reset4();
        for (int i = 0; i < 7; i++) begin
            ena4 = (i == 0 || i == 6);
            pi4  = 4'($urandom);
            tick();
            if (i == 0)      exp = {4'h1, 4'h3, 1'b1, 1'b0, 1'b0};
            else if (i == 6) exp = {4'hA, 4'h3, 1'b0, 1'b0, 1'b0};
            else             exp = {4'h1, 4'h3, 1'b0, 1'b0, 1'b0};
            n_chk++;
            if (obs4() !== exp) begin
                n_fail++;
                $display("FAIL enable[%0d]: got %h expected %h", i, obs4(), exp);
            end
        end
    endtask

    task automatic test_wrap8();
        logic [18:0] exp [7];
        exp = '{ {8'hFF, 8'h00, 1'b0, 1'b0, 1'b0},
                 {8'h00, 8'h00, 1'b0, 1'b0, 1'b0},
                 {8'h01, 8'h00, 1'b0, 1'b0, 1'b0},
                 {8'h02, 8'h00, 1'b0, 1'b0, 1'b0},
                 {8'h03, 8'h00, 1'b0, 1'b1, 1'b0},
                 {8'h04, 8'h00, 1'b0, 1'b0, 1'b0},
                 {8'h05, 8'h11, 1'b1, 1'b0, 1'b0} };
        for (int i = 0; i < 256; i++) mem8[i] = 12'hD00;
        mem8[0] = 12'hFFF;
        reset8();
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                mem8[0] = 12'h380; mem8[1] = 12'h780; mem8[2] = 12'h800;
                mem8[3] = 12'h400; mem8[4] = 12'h911;
                reset8();
            end
            tick();
            n_chk++;
            if (obs8() !== exp[i]) begin
                n_fail++;
                $display("FAIL wrap8[%0d]: got %h expected %h", i, obs8(), exp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  ins;
        logic [10:0] exp;
        for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom);
        rst4 = 1'b1;
        for (int i = 0; i < 600; i++) begin
            ins = mem4[m_pc];
            tick();
            model_step(rst4, ena4, ins, int'(pi4));
            exp = {4'(m_pc), 4'(m_po), m_stb, m_cf, m_halt};
            n_chk++;
            if (obs4() !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs4(), exp);
            end
            rst4 = ($urandom_range(0, 39) == 0);
            ena4 = ($urandom_range(0, 4) != 0);
            pi4  = 4'($urandom);
            if (rst4) for (int k = 0; k < 16; k++) mem4[k] = 8'($urandom);
        end
        rst4 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem8[i] = 12'hD00;
        clear4();
        test_reset();
        test_carry();
        test_jumps();
        test_out();
        test_halt();
        test_enable();
        test_wrap8();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/td4_core_param.md
TD4_CORE_PARAM -- requirements
Module: td4_core_param

Interface
REQ-001 SHALL have parameter W, default 4: register, port, immediate and address width; legal range 4..8.
REQ-002 SHALL have parameter INSTR_W, fixed at 4+W: instruction width, {opcode[3:0], imm[W-1:0]}.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port ena, input, 1 bit: execute enable; when low, all architectural state holds.
REQ-006 SHALL have port addres, output, W bits: program counter, which is the instruction fetch address.
REQ-007 SHALL have port data, input, INSTR_W bits: the instruction at addres, read combinationally in the same cycle.
REQ-008 SHALL have port port_i, input, W bits: input port.
REQ-009 SHALL have port port_o, output, W bits: registered output port.
REQ-010 SHALL have port port_o_stb, output, 1 bit: one-cycle pulse in the cycle after an OUT instruction executes.
REQ-011 SHALL have port cf, output, 1 bit: registered carry flag.
REQ-012 SHALL have port halted, output, 1 bit: high while the core is in state HALT.

Function
REQ-013 SHALL implement a two-state FSM with states RUN and HALT; an executed HALT opcode moves RUN->HALT; only rst leaves HALT.
REQ-014 SHALL execute exactly one instruction per clk edge when state=RUN and ena=1. No pipeline; latency is 1 cycle to every register.
REQ-015 SHALL form every result as sum = src + imm, W+1 bits wide. The result is sum[W-1:0] and the carry is sum[W]. Results wrap modulo 2^W.
REQ-016 SHALL decode opcodes as follows, with src and destination:
- 0000 ADD A,imm: A+imm -> A.
- 0001 MOV A,B: B+imm -> A.
- 0010 IN A: port_i+imm -> A.
- 0011 MOV A,imm: 0+imm -> A.
- 0100 MOV B,A: A+imm -> B.
- 0101 ADD B,imm: B+imm -> B.
- 0110 IN B: port_i+imm -> B.
- 0111 MOV B,imm: 0+imm -> B.
- 1000 ADD A,B: A+B -> A, imm ignored (new).
- 1001 OUT B: B+imm -> port_o.
- 1010 HALT (new).
- 1011 OUT imm: 0+imm -> port_o.
- 1100 JC imm: 0+imm -> PC if cf=1 (new).
- 1101 NOP (new).
- 1110 JNC imm: 0+imm -> PC if cf=0.
- 1111 JMP imm: 0+imm -> PC.
REQ-017 SHALL increment PC by 1 modulo 2^W on every executed instruction that does not load PC, including a JC or JNC whose condition is not taken.
REQ-018 SHALL evaluate the JC/JNC condition on the cf value held before the instruction executes.
REQ-019 SHALL load cf with the ALU carry on every executed instruction except NOP and HALT, which hold cf. Consequently MOV/IN/OUT/jump instructions with a carry-free sum clear cf.
REQ-020 SHALL freeze PC, A, B, port_o and cf when executing HALT.
REQ-021 SHALL assert port_o_stb for exactly one cycle following each executed OUT B or OUT imm, including when the value written equals the previous port_o value.
REQ-022 SHALL keep all state unchanged and deassert port_o_stb when ena=0. ena has no effect in HALT.
REQ-023 SHALL ignore data and port_i in any cycle where no instruction executes.

Reset
REQ-024 SHALL, when rst=1 at a clk edge, set PC=0, A=0, B=0, port_o=0, cf=0, port_o_stb=0 and state=RUN, overriding ena and any instruction.
REQ-025 SHALL give reset priority when rst is asserted mid-operation, including in HALT; execution restarts at address 0 on the first edge with rst=0.

Verification
REQ-026 SHALL cover carry generation. Stimulus: W=4; MOV A,0xF; ADD A,0x1. Required response: A=0x0, cf=1, PC=2.
REQ-027 SHALL cover the conditional jumps. Stimulus: cf=1, then JNC 0x9. Required response: PC=prev+1, cf=0. Stimulus: next JC 0x9. Required response: not taken, because cf is now 0.
REQ-028 SHALL cover OUT and the strobe. Stimulus: MOV B,0x5; OUT B. Required response: port_o=0x5, and port_o_stb high for exactly one cycle after the OUT.
REQ-029 SHALL cover HALT. Stimulus: HALT at address 3. Required response: halted=1, PC stays 3 for 10 cycles. Stimulus: rst. Required response: halted=0, PC=0.
REQ-030 SHALL cover enable. Stimulus: ena=0 for 5 cycles during a JMP 0xA. Required response: no state change; the JMP executes on the first cycle ena=1.
REQ-031 SHALL cover wrap-around at W=8. Stimulus: PC=0xFF executing NOP. Required response: PC=0x00. Stimulus: ADD A,B with A=0x80, B=0x80. Required response: A=0x00, cf=1.
